// File: rtl/match_sequencer.sv
// ============================================================================
//  match_sequencer
//  Game-flow controller: title/serve/rally/pause/point/over sequencing,
//  BCD score keeping and status outputs for the volleyball design.
//  Rev 1.0  initial release
// ============================================================================
`default_nettype none

module match_sequencer #(
   parameter int WIN_SCORE    = 15,
   parameter int FREEZE_TICKS = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        start,
   input  logic        pause,
   input  logic        ball_land,
   input  logic        land_side,
   output logic        play_en,
   output logic        round_rst,
   output logic        serve_side,
   output logic        show_title,
   output logic [15:0] scores,
   output logic        winner,
   output logic [15:0] led
);

   localparam logic [2:0] S_TITLE  = 3'd0;
   localparam logic [2:0] S_SERVE  = 3'd1;
   localparam logic [2:0] S_RALLY  = 3'd2;
   localparam logic [2:0] S_PAUSED = 3'd3;
   localparam logic [2:0] S_POINT  = 3'd4;
   localparam logic [2:0] S_OVER   = 3'd5;

   localparam logic [15:0] c_led_title  = 16'h0001;
   localparam logic [15:0] c_led_serve  = 16'h0002;
   localparam logic [15:0] c_led_rally  = 16'h0004;
   localparam logic [15:0] c_led_paused = 16'h0008;
   localparam logic [15:0] c_led_point  = 16'h0010;

   localparam logic [7:0] c_win_bcd     = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
   localparam logic [7:0] c_freeze_last = 8'(FREEZE_TICKS - 1);

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   logic [2:0]  r_state;
   logic [7:0]  r_freeze_cnt;
   logic [7:0]  r_p1;
   logic [7:0]  r_p2;
   logic        r_play_en;
   logic        r_round_rst;
   logic        r_serve_side;
   logic        r_show_title;
   logic        r_winner;
   logic [15:0] r_led;

   logic [7:0]  w_p1_inc;
   logic [7:0]  w_p2_inc;
   logic [7:0]  w_new_score;

   // land_side=1 means the ball fell on the right half, so player1 scores
   assign w_p1_inc    = bcd_inc(r_p1);
   assign w_p2_inc    = bcd_inc(r_p2);
   assign w_new_score = land_side ? w_p1_inc : w_p2_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_TITLE;
         r_freeze_cnt <= 8'd0;
         r_p1         <= 8'd0;
         r_p2         <= 8'd0;
         r_play_en    <= 1'b0;
         r_round_rst  <= 1'b0;
         r_serve_side <= 1'b0;
         r_show_title <= 1'b1;
         r_winner     <= 1'b0;
         r_led        <= c_led_title;
      end else begin
         r_round_rst <= 1'b0;
         case (r_state)
            S_TITLE: begin
               if (start) begin
                  r_state      <= S_SERVE;
                  r_serve_side <= 1'b0;
                  r_round_rst  <= 1'b1;
                  r_show_title <= 1'b0;
                  r_led        <= c_led_serve;
               end
            end
            S_SERVE: begin
               r_state   <= S_RALLY;
               r_play_en <= 1'b1;
               r_led     <= c_led_rally;
            end
            S_RALLY: begin
               if (ball_land) begin
                  r_play_en    <= 1'b0;
                  r_serve_side <= ~land_side;
                  if (land_side) r_p1 <= w_p1_inc;
                  else           r_p2 <= w_p2_inc;
                  if (w_new_score == c_win_bcd) begin
                     r_state  <= S_OVER;
                     r_winner <= ~land_side;
                     r_led    <= land_side ? 16'hFF00 : 16'h00FF;
                  end else begin
                     r_state      <= S_POINT;
                     r_freeze_cnt <= 8'd0;
                     r_led        <= c_led_point;
                  end
               end else if (pause) begin
                  r_state   <= S_PAUSED;
                  r_play_en <= 1'b0;
                  r_led     <= c_led_paused;
               end
            end
            S_PAUSED: begin
               if (pause) begin
                  r_state   <= S_RALLY;
                  r_play_en <= 1'b1;
                  r_led     <= c_led_rally;
               end
            end
            S_POINT: begin
               // the FREEZE_TICKS-th tick since entry ends the freeze
               if (tick) begin
                  if (r_freeze_cnt == c_freeze_last) begin
                     r_state     <= S_SERVE;
                     r_round_rst <= 1'b1;
                     r_led       <= c_led_serve;
                  end else begin
                     r_freeze_cnt <= r_freeze_cnt + 8'd1;
                  end
               end
            end
            S_OVER: begin
               if (start) begin
                  r_state      <= S_TITLE;
                  r_p1         <= 8'd0;
                  r_p2         <= 8'd0;
                  r_serve_side <= 1'b0;
                  r_show_title <= 1'b1;
                  r_led        <= c_led_title;
               end
            end
            default: begin
               r_state      <= S_TITLE;
               r_play_en    <= 1'b0;
               r_show_title <= 1'b1;
               r_led        <= c_led_title;
            end
         endcase
      end
   end

   assign play_en    = r_play_en;
   assign round_rst  = r_round_rst;
   assign serve_side = r_serve_side;
   assign show_title = r_show_title;
   assign scores     = {r_p1, r_p2};
   assign winner     = r_winner;
   assign led        = r_led;

endmodule

`default_nettype wire

// File: tb/tb_match_sequencer.sv
// ============================================================================
//  tb_match_sequencer
//  Directed plus randomized bench against an integer-score match model.
//  Rev 1.0  initial release
// ============================================================================
`default_nettype none

module tb_match_sequencer;

   localparam int WIN_SCORE    = 15;
   localparam int FREEZE_TICKS = 60;

   localparam int ST_TITLE  = 0;
   localparam int ST_SERVE  = 1;
   localparam int ST_RALLY  = 2;
   localparam int ST_PAUSED = 3;
   localparam int ST_POINT  = 4;
   localparam int ST_OVER   = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick = 1'b0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        ball_land = 1'b0;
   logic        land_side = 1'b0;
   logic        play_en;
   logic        round_rst;
   logic        serve_side;
   logic        show_title;
   logic [15:0] scores;
   logic        winner;
   logic [15:0] led;

   match_sequencer #(.WIN_SCORE(WIN_SCORE), .FREEZE_TICKS(FREEZE_TICKS)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .start      (start),
      .pause      (pause),
      .ball_land  (ball_land),
      .land_side  (land_side),
      .play_en    (play_en),
      .round_rst  (round_rst),
      .serve_side (serve_side),
      .show_title (show_title),
      .scores     (scores),
      .winner     (winner),
      .led        (led)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model: plain integers for scores, state as a small code
   int m_st = ST_TITLE;
   int m_p1 = 0;
   int m_p2 = 0;
   int m_cnt = 0;
   int m_serve = 0;
   int m_winner = 0;
   int m_rr = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [15:0] exp_led();
      if (m_st == ST_OVER) return (m_winner != 0) ? 16'h00FF : 16'hFF00;
      return 16'(1 << m_st);
   endfunction

   task automatic model_step(input logic r, s, p, bl, ls, t);
      m_rr = 0;
      if (r) begin
         m_st = ST_TITLE; m_p1 = 0; m_p2 = 0; m_cnt = 0; m_serve = 0; m_winner = 0;
         return;
      end
      case (m_st)
         ST_TITLE: if (s) begin m_st = ST_SERVE; m_serve = 0; m_rr = 1; end
         ST_SERVE: m_st = ST_RALLY;
         ST_RALLY: begin
            if (bl) begin
               int sc;
               if (ls) begin m_p1++; sc = m_p1; m_serve = 0; end
               else    begin m_p2++; sc = m_p2; m_serve = 1; end
               if (sc == WIN_SCORE) begin m_st = ST_OVER; m_winner = ls ? 0 : 1; end
               else begin m_st = ST_POINT; m_cnt = 0; end
            end else if (p) m_st = ST_PAUSED;
         end
         ST_PAUSED: if (p) m_st = ST_RALLY;
         ST_POINT: if (t) begin
            m_cnt++;
            if (m_cnt == FREEZE_TICKS) begin m_st = ST_SERVE; m_rr = 1; end
         end
         ST_OVER: if (s) begin m_st = ST_TITLE; m_p1 = 0; m_p2 = 0; m_serve = 0; end
         default: m_st = ST_TITLE;
      endcase
   endtask

   task automatic check_all();
      check("play_en",    16'(play_en),    16'(m_st == ST_RALLY));
      check("round_rst",  16'(round_rst),  16'(m_rr));
      check("serve_side", 16'(serve_side), 16'(m_serve));
      check("show_title", 16'(show_title), 16'(m_st == ST_TITLE));
      check("scores",     scores,          {to_bcd(m_p1), to_bcd(m_p2)});
      check("led",        led,             exp_led());
      if (m_st == ST_OVER) check("winner", 16'(winner), 16'(m_winner));
   endtask

   task automatic cyc(input logic r, s, p, bl, ls, t);
      rst = r; start = s; pause = p; ball_land = bl; land_side = ls; tick = t;
      @(posedge clk);
      model_step(r, s, p, bl, ls, t);
      #1;
      check_all();
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0);
   endtask

   // one landing followed by the full freeze and the serve cycle
   task automatic score_point(input logic side);
      cyc(0, 0, 0, 1, side, 0);
      if (m_st == ST_OVER) return;
      for (int i = 0; i < FREEZE_TICKS; i++) cyc(0, 0, 0, 0, 0, 1);
      idle();
   endtask

   initial begin
      @(negedge clk);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 1, 1, 1);
      check("rst_led", led, 16'h0001);
      check("rst_scores", scores, 16'h0000);

      cyc(0, 1, 0, 0, 0, 0);
      check("start_rr", 16'(round_rst), 16'h0001);
      check("start_title", 16'(show_title), 16'h0000);
      idle();
      check("rally_play", 16'(play_en), 16'h0001);

      cyc(0, 0, 0, 1, 1, 0);
      check("p1_point", scores, 16'h0100);
      for (int i = 0; i < FREEZE_TICKS - 1; i++) cyc(0, 0, 0, 0, 0, 1);
      check("freeze_hold", led, 16'h0010);
      cyc(0, 0, 0, 0, 0, 1);
      check("freeze_end_rr", 16'(round_rst), 16'h0001);
      idle();

      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      check("pause_twice", led, 16'h0004);
      cyc(0, 0, 1, 1, 0, 0);
      check("land_beats_pause", led, 16'h0010);
      check("land_beats_pause_sc", scores, 16'h0101);
      cyc(0, 0, 1, 0, 0, 0);
      check("pause_in_point", led, 16'h0010);
      for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 1);
      check("mid_freeze_rst", led, 16'h0001);
      check("mid_freeze_rst_sc", scores, 16'h0000);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 1, 1);
      check("title_holds", 16'(show_title), 16'h0001);

      cyc(0, 1, 0, 0, 0, 0);
      idle();
      for (int i = 0; i < 10; i++) score_point(1'b0);
      check("bcd_carry", 16'(scores[7:0]), 16'h0010);
      for (int i = 0; i < WIN_SCORE; i++) score_point(1'b1);
      check("win_led", led, 16'hFF00);
      check("win_p1", 16'(scores[15:8]), 16'h0015);
      check("win_who", 16'(winner), 16'h0000);
      cyc(0, 1, 0, 0, 0, 0);
      check("over_to_title", scores, 16'h0000);

      for (int n = 0; n < 30000; n++) begin
         cyc(($urandom_range(0, 2999) == 0),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
